// File: rtl/prog_pkg.sv
// Shared definitions for the accumulator CPU boot/run sequencer: state codes,
// host command encodings and the default RAM geometry.
package prog_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ARM     = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4,
    ST_TIMEOUT = 3'd5
  } state_t;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_CLEAR = 2'b01;
  localparam logic [1:0] CMD_RUN   = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  // The CPU drives the RAM only while it is running or sitting halted.
  function automatic logic cpu_owns_ram(input state_t s);
    return (s == ST_RUN) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/prog_run_ctrl_if.sv
// Host, command, CPU-side and RAM-side signals of the boot/run sequencer.
interface prog_run_ctrl_if
  import prog_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
);
  logic              host_valid;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              cmd_valid;
  logic [1:0]        cmd;
  logic              cpu_halt;
  logic [ADDR_W-1:0] cpu_mem_addr;
  logic [DATA_W-1:0] cpu_mem_data;
  logic              cpu_mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wr;
  logic              cpu_reset_n;
  logic              busy;
  logic [2:0]        status;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output host_valid, host_addr, host_data, cmd_valid, cmd,
           cpu_halt, cpu_mem_addr, cpu_mem_data, cpu_mem_wr,
    input  host_ready, mem_addr, mem_data, mem_wr,
           cpu_reset_n, busy, status, cycle_count
  );

  modport slave (
    input  host_valid, host_addr, host_data, cmd_valid, cmd,
           cpu_halt, cpu_mem_addr, cpu_mem_data, cpu_mem_wr,
    output host_ready, mem_addr, mem_data, mem_wr,
           cpu_reset_n, busy, status, cycle_count
  );
endinterface

// File: rtl/prog_run_ctrl_mem_owner_mux.sv
// Program RAM port selection: the CPU owns the port in RUN/DONE, the loader
// registers own it everywhere else. Purely combinational so the handover
// happens in the same cycle as the state change.
module mem_owner_mux
  import prog_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  state_t            state,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data
);

  // Select the RAM source from the current owner.
  always_comb begin
    if (cpu_owns_ram(state)) begin
      mem_wr   = cpu_wr;
      mem_addr = cpu_addr;
      mem_data = cpu_data;
    end else begin
      mem_wr   = ld_wr;
      mem_addr = ld_addr;
      mem_data = ld_data;
    end
  end

endmodule

// File: rtl/prog_run_ctrl.sv
// Boot and run sequencer for the accumulator CPU: host loading and clearing
// of program RAM with the CPU held in reset, run hand-off, halt detection and
// a cycle-budget watchdog.
module prog_run_ctrl
  import prog_pkg::*;
#(
  parameter int               ADDR_W     = ADDR_W_DEF,
  parameter int               DATA_W     = DATA_W_DEF,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] MAX_CYCLES = {CNT_W{1'b1}}
) (
  input logic            clk,
  input logic            rst,
  prog_run_ctrl_if.slave bus
);

  // Last address of the sweep plus one; the sweep ends when it is reached.
  localparam logic [ADDR_W:0]  SWEEP_END = {1'b1, {ADDR_W{1'b0}}};
  // Count value seen in the final RUN cycle the budget allows.
  localparam logic [CNT_W-1:0] LAST_CYC  = MAX_CYCLES - 1'b1;

  state_t            state;
  logic              cpu_reset_n_q;
  logic [CNT_W-1:0]  cycle_cnt;
  logic              ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W:0]   clr_next;

  logic              host_ready;
  logic              hs;
  logic              cmd_clear;
  logic              cmd_run;
  logic              cmd_abort;
  logic              mux_wr;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_data;

  assign host_ready = (state == ST_IDLE) && !rst;
  assign hs         = bus.host_valid && host_ready;
  assign cmd_clear  = bus.cmd_valid && (bus.cmd == CMD_CLEAR);
  assign cmd_run    = bus.cmd_valid && (bus.cmd == CMD_RUN);
  assign cmd_abort  = bus.cmd_valid && (bus.cmd == CMD_ABORT);

  // Sequencer state, loader write registers, CPU reset and cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cpu_reset_n_q <= 1'b0;
      cycle_cnt     <= '0;
      ld_wr         <= 1'b0;
      ld_addr       <= '0;
      ld_data       <= '0;
      clr_next      <= '0;
    end else begin
      ld_wr <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_TIMEOUT: begin
          // Host writes only arrive in IDLE (ready is low elsewhere).
          if (hs) begin
            ld_wr   <= 1'b1;
            ld_addr <= bus.host_addr;
            ld_data <= bus.host_data;
          end
          if (cmd_clear) begin
            state         <= ST_CLEAR;
            cpu_reset_n_q <= 1'b0;
            if (hs) begin
              // The host write takes the first CLEAR cycle; sweep follows.
              clr_next <= '0;
            end else begin
              ld_wr    <= 1'b1;
              ld_addr  <= '0;
              ld_data  <= '0;
              clr_next <= {{ADDR_W{1'b0}}, 1'b1};
            end
          end else if (cmd_run) begin
            state         <= ST_ARM;
            cpu_reset_n_q <= 1'b0;
            cycle_cnt     <= '0;
          end else if (cmd_abort) begin
            state         <= ST_IDLE;
            cpu_reset_n_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (cmd_abort || (clr_next == SWEEP_END)) begin
            state <= ST_IDLE;
          end else begin
            ld_wr    <= 1'b1;
            ld_addr  <= clr_next[ADDR_W-1:0];
            ld_data  <= '0;
            clr_next <= clr_next + 1'b1;
          end
        end
        ST_ARM: begin
          state         <= ST_RUN;
          cpu_reset_n_q <= 1'b1;
        end
        ST_RUN: begin
          // The current cycle counts even when it is the one that ends the run.
          cycle_cnt <= cycle_cnt + 1'b1;
          if (cmd_abort) begin
            state         <= ST_IDLE;
            cpu_reset_n_q <= 1'b0;
          end else if (bus.cpu_halt) begin
            state <= ST_DONE;
          end else if (cycle_cnt == LAST_CYC) begin
            state         <= ST_TIMEOUT;
            cpu_reset_n_q <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          cpu_reset_n_q <= 1'b0;
        end
      endcase
    end
  end

  mem_owner_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_owner_mux (
    .state    (state),
    .ld_wr    (ld_wr),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .cpu_wr   (bus.cpu_mem_wr),
    .cpu_addr (bus.cpu_mem_addr),
    .cpu_data (bus.cpu_mem_data),
    .mem_wr   (mux_wr),
    .mem_addr (mux_addr),
    .mem_data (mux_data)
  );

  assign bus.host_ready  = host_ready;
  assign bus.mem_wr      = mux_wr;
  assign bus.mem_addr    = mux_addr;
  assign bus.mem_data    = mux_data;
  assign bus.cpu_reset_n = cpu_reset_n_q;
  assign bus.busy        = (state == ST_CLEAR) || (state == ST_ARM) || (state == ST_RUN);
  assign bus.status      = state;
  assign bus.cycle_count = cycle_cnt;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl with a 20-cycle run budget.
module tb_prog_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  prog_run_ctrl_if #(.ADDR_W(5), .DATA_W(8), .CNT_W(16)) bus ();

  prog_run_ctrl #(
    .ADDR_W     (5),
    .DATA_W     (8),
    .CNT_W      (16),
    .MAX_CYCLES (16'd20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic command(input logic [1:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
  endtask

  // {mem_wr, busy, status, mem_addr, mem_data}
  function automatic logic [31:0] ram_view();
    return {14'd0, bus.mem_wr, bus.busy, bus.status, bus.mem_addr, bus.mem_data};
  endfunction

  function automatic logic [31:0] ram_exp(input logic wr, input logic bsy,
                                          input logic [2:0] st, input logic [4:0] a,
                                          input logic [7:0] d);
    return {14'd0, wr, bsy, st, a, d};
  endfunction

  initial begin
    bus.host_valid   = 1'b0;
    bus.host_addr    = '0;
    bus.host_data    = '0;
    bus.cmd_valid    = 1'b0;
    bus.cmd          = 2'b00;
    bus.cpu_halt     = 1'b0;
    bus.cpu_mem_addr = 5'h03;
    bus.cpu_mem_data = 8'h77;
    bus.cpu_mem_wr   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ready", bus.host_ready, 0);
    check("rst_ram", ram_view(), ram_exp(1'b0, 1'b0, 3'd0, 5'd0, 8'h00));
    check("rst_cpurst", bus.cpu_reset_n, 0);
    check("rst_count", bus.cycle_count, 0);
    rst = 1'b0;
    #1;
    check("idle_ready", bus.host_ready, 1);

    // Back-to-back host writes
    bus.host_valid = 1'b1;
    bus.host_addr  = 5'd0;
    bus.host_data  = 8'h05;
    tick();
    check("wr0", ram_view(), ram_exp(1'b1, 1'b0, 3'd0, 5'd0, 8'h05));
    check("wr0_ready", bus.host_ready, 1);
    bus.host_addr  = 5'd1;
    bus.host_data  = 8'hE0;
    tick();
    bus.host_valid = 1'b0;
    check("wr1", ram_view(), ram_exp(1'b1, 1'b0, 3'd0, 5'd1, 8'hE0));
    check("wr1_ready", bus.host_ready, 1);
    tick();
    check("wr_idle", bus.mem_wr, 0);

    // Full clear sweep
    command(2'b01);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("clr%0d", i), ram_view(), ram_exp(1'b1, 1'b1, 3'd1, 5'(i), 8'h00));
      tick();
    end
    check("clr_end", ram_view(), ram_exp(1'b0, 1'b0, 3'd0, 5'd31, 8'h00));

    // Clear aborted in its 10th cycle
    command(2'b01);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("abt_last", ram_view(), ram_exp(1'b1, 1'b1, 3'd1, 5'd9, 8'h00));
    command(2'b11);
    tick();
    bus.cmd_valid = 1'b0;
    check("abt_idle", ram_view(), ram_exp(1'b0, 1'b0, 3'd0, 5'd9, 8'h00));
    tick();
    check("abt_quiet1", bus.mem_wr, 0);
    tick();
    check("abt_quiet2", bus.mem_wr, 0);

    // Load halt instruction together with the run command
    bus.host_valid = 1'b1;
    bus.host_addr  = 5'd0;
    bus.host_data  = 8'hE0;
    command(2'b10);
    tick();
    bus.host_valid = 1'b0;
    bus.cmd_valid  = 1'b0;
    check("arm_wr", ram_view(), ram_exp(1'b1, 1'b1, 3'd2, 5'd0, 8'hE0));
    check("arm_cpurst", bus.cpu_reset_n, 0);
    check("arm_count", bus.cycle_count, 0);
    check("arm_ready", bus.host_ready, 0);
    tick();
    check("run_ram", ram_view(), ram_exp(1'b0, 1'b1, 3'd3, 5'd3, 8'h77));
    check("run_cpurst", bus.cpu_reset_n, 1);
    check("run_count0", bus.cycle_count, 0);
    tick();
    tick();
    tick();
    check("run_count3", bus.cycle_count, 3);
    bus.cpu_halt = 1'b1;
    tick();
    bus.cpu_halt = 1'b0;
    check("done_status", bus.status, 4);
    check("done_count", bus.cycle_count, 4);
    check("done_cpurst", bus.cpu_reset_n, 1);
    bus.cpu_mem_wr = 1'b1;
    #1;
    check("done_cpuwr", bus.mem_wr, 1);
    tick();
    bus.cpu_mem_wr = 1'b0;
    check("done_frozen", bus.cycle_count, 4);

    // Watchdog timeout after 20 RUN cycles, clear ignored while running
    command(2'b10);
    tick();
    bus.cmd_valid = 1'b0;
    check("arm2_status", bus.status, 2);
    check("arm2_count", bus.cycle_count, 0);
    tick();
    for (int k = 0; k < 20; k++) begin
      check($sformatf("wd_run%0d", k), {bus.status, bus.cycle_count}, {3'd3, 16'(k)});
      if (k == 5) command(2'b01);
      tick();
      bus.cmd_valid = 1'b0;
    end
    check("to_status", bus.status, 5);
    check("to_count", bus.cycle_count, 20);
    check("to_cpurst", bus.cpu_reset_n, 0);
    check("to_busy", bus.busy, 0);
    bus.cpu_mem_wr = 1'b1;
    #1;
    check("to_loader_owns", bus.mem_wr, 0);
    tick();
    bus.cpu_mem_wr = 1'b0;
    check("to_frozen", bus.cycle_count, 20);
    command(2'b10);
    tick();
    bus.cmd_valid = 1'b0;
    check("arm3_status", bus.status, 2);
    check("arm3_count", bus.cycle_count, 0);

    // Halt and abort in the same RUN cycle: abort wins
    tick();
    tick();
    check("run3_status", bus.status, 3);
    bus.cpu_halt = 1'b1;
    command(2'b11);
    tick();
    bus.cpu_halt  = 1'b0;
    bus.cmd_valid = 1'b0;
    check("hab_status", bus.status, 0);
    check("hab_cpurst", bus.cpu_reset_n, 0);
    check("hab_busy", bus.busy, 0);

    // Reset in the middle of a clear sweep
    command(2'b01);
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_clr", bus.status, 1);
    rst = 1'b1;
    tick();
    check("mid_rst", ram_view(), ram_exp(1'b0, 1'b0, 3'd0, 5'd0, 8'h00));
    check("mid_ready", bus.host_ready, 0);
    rst = 1'b0;
    #1;
    check("mid_ready_back", bus.host_ready, 1);
    tick();
    check("mid_quiet", bus.mem_wr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
- Boot and run sequencer for the accumulator CPU (control unit plus datapath plus 2^ADDR_W x DATA_W program RAM).
- Owns the program RAM while a host loads or clears it, with the CPU held in reset.
- Hands RAM ownership to the CPU on a run command.
- Detects CPU halt, and enforces a cycle-budget watchdog that aborts runaway programs.

Parameters:
- ADDR_W, 5, program RAM address width (matches the IR[4:0] operand field).
- DATA_W, 8, RAM word width.
- CNT_W, 16, cycle counter width.
- MAX_CYCLES, 16'hFFFF, CPU cycle budget per run; must satisfy MAX_CYCLES >= 1.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- HostValid  in  1  host write request.
- HostReady  out  1  loader accepts a host write this cycle.
- HostAddr  in  ADDR_W  host write address.
- HostData  in  DATA_W  host write data.
- CmdValid  in  1  command strobe, single cycle.
- Cmd  in  2  command: 00 nop, 01 clear, 10 run, 11 abort.
- CpuHalt  in  1  control unit Halt output.
- CpuMemAddr  in  ADDR_W  CPU RAM address.
- CpuMemData  in  DATA_W  CPU RAM write data.
- CpuMemWr  in  1  CPU RAM write enable.
- MemAddr  out  ADDR_W  RAM address.
- MemData  out  DATA_W  RAM write data.
- MemWr  out  1  RAM write enable.
- CpuReset_n  out  1  active-low reset to the control unit, registered.
- Busy  out  1  high in CLEAR, ARM and RUN.
- Status  out  3  current state code.
- CycleCount  out  CNT_W  CPU cycles elapsed in the current run.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Reset values:
  - state IDLE
  - CpuReset_n=0
  - MemWr=0, MemAddr=0, MemData=0
  - CycleCount=0
  - HostReady=0 while Reset is high.
- State codes: IDLE=0, CLEAR=1, ARM=2, RUN=3, DONE=4, TIMEOUT=5. Status equals the state code.
- RAM mux:
  - In RUN and DONE, Mem* follow Cpu* combinationally.
  - In all other states, Mem* come from loader registers, and MemWr is 0 unless a write is issuing.
- IDLE:
  - HostReady=1 and CpuReset_n=0.
  - A handshake is HostValid & HostReady. One cycle after the handshake: MemWr=1 with the captured HostAddr/HostData. Back-to-back handshakes give one write per cycle.
  - Cmd clear goes to CLEAR. Cmd run goes to ARM. Abort and nop: stay.
- A host handshake in the same cycle as an accepted command still issues its write in the next cycle, which is the first cycle of CLEAR or ARM. The CLEAR sweep starts one cycle later in that case.
- CLEAR:
  - HostReady=0.
  - Internal counter runs 0..2^ADDR_W-1 with MemWr=1, MemAddr=counter, MemData=0. That is 2^ADDR_W cycles, then IDLE.
  - Abort: stop the sweep, go to IDLE next cycle. Run and clear are ignored.
- ARM:
  - Exactly one cycle. CpuReset_n=0, CycleCount cleared to 0. Then RUN.
  - Commands are ignored in ARM.
- RUN:
  - CpuReset_n=1 from the first RUN cycle (registered at the ARM-to-RUN transition).
  - CycleCount increments every RUN cycle.
  - Priority per cycle: abort > CpuHalt > watchdog.
    - abort: go to IDLE, CpuReset_n=0 next cycle.
    - CpuHalt=1: go to DONE, CycleCount frozen.
    - CycleCount==MAX_CYCLES-1 while incrementing: go to TIMEOUT, CpuReset_n=0, CycleCount=MAX_CYCLES frozen.
  - Run and clear are ignored.
- DONE:
  - CpuReset_n stays 1 so the CPU remains halted and visible. RAM stays CPU-owned.
  - clear goes to CLEAR. run goes to ARM. abort goes to IDLE.
- TIMEOUT:
  - CpuReset_n=0, CycleCount frozen.
  - Same command transitions as DONE.
- On leaving RUN or DONE, the RAM mux switches to the loader in the same cycle as the state change.
- Reset mid-operation, in any state, returns to IDLE on the next edge. A clear in progress is abandoned and a pending host write is dropped.
- CycleCount never wraps. Saturation at MAX_CYCLES is guaranteed by the watchdog.

Decomposition:
- Shared package prog_pkg holds:
  - the state enum and codes
  - the Cmd encodings (CMD_NOP, CMD_CLEAR, CMD_RUN, CMD_ABORT)
  - the ADDR_W/DATA_W defaults, shared with the control unit and datapath.
- One natural sub-module, mem_owner_mux: the combinational RAM port selection between the loader and CPU sources, selected by the state.

Test Plan:
1. Reset, then host writes 0x05->addr 0, 0xE0->addr 1 back-to-back → MemWr=1 on the two following cycles with matching address/data; HostReady=1 throughout.
2. Cmd clear from IDLE → 32 consecutive MemWr cycles at addresses 0..31 with data 0x00, Busy=1, then Status=0.
3. Cmd abort at the 10th CLEAR cycle → MemWr stops, Status=0 next cycle, addresses 10..31 untouched.
4. Load a halt instruction (0xE0) at addr 0, then Cmd run → Status 2 for 1 cycle then 3, CpuReset_n rises. After the CPU asserts Halt: Status=4, CycleCount frozen at the cycles spent in RUN up to and including the Halt cycle (4 with the stock control unit), CpuReset_n stays 1.
5. MAX_CYCLES=20, program with a self-loop jump, Cmd run → after 20 RUN cycles Status=5, CycleCount=20, CpuReset_n=0. Then Cmd run → ARM, CycleCount=0.
6. CpuHalt and Cmd abort in the same RUN cycle → Status=0, CpuReset_n=0.
